// File: rtl/instr_encoder_loader.sv
// Program loader: encodes MIPS-style mnemonic requests into 32-bit words and
// streams them into instruction memory at consecutive byte addresses.

module instr_encoder (
    input  logic [3:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] jaddr,
    output logic [31:0] word,
    output logic        ok
);
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_XORI = 6'h0e;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_JR   = 6'h08;

    always_comb begin
        word = 32'h0;
        ok   = 1'b1;
        case (mnem)
            4'd0:  word = {OP_LW,   rs, rt, imm};
            4'd1:  word = {OP_SW,   rs, rt, imm};
            4'd2:  word = {OP_J,    jaddr};
            4'd3:  word = {OP_JAL,  jaddr};
            4'd4:  word = {OP_BEQ,  rs, rt, imm};
            4'd5:  word = {OP_BNE,  rs, rt, imm};
            4'd6:  word = {OP_XORI, rs, rt, imm};
            4'd7:  word = {OP_ADDI, rs, rt, imm};
            4'd8:  word = {6'h0, rs, rt, rd, 5'h0, FN_ADD};
            4'd9:  word = {6'h0, rs, rt, rd, 5'h0, FN_SUB};
            4'd10: word = {6'h0, rs, rt, rd, 5'h0, FN_SLT};
            4'd11: word = {6'h0, rs, 15'h0, FN_JR};
            default: ok = 1'b0;
        endcase
    end
endmodule

module instr_encoder_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [3:0]  inMnem,
    input  logic [4:0]  inRs,
    input  logic [4:0]  inRt,
    input  logic [4:0]  inRd,
    input  logic [15:0] inImm,
    input  logic [25:0] inJAddr,
    input  logic        finish,
    output logic        imWe,
    output logic [31:0] imAddr,
    output logic [31:0] imWData,
    output logic [10:0] count,
    output logic        full,
    output logic        loadDone,
    output logic        err
);
    typedef enum logic [1:0] {LOAD, FULL, DONE} state_t;

    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    state_t      state, state_nx;
    logic [10:0] cnt;
    logic [31:0] enc_word;
    logic        enc_ok;
    logic        accept, write, last, done_entry;

    instr_encoder u_enc (
        .mnem  (inMnem),
        .rs    (inRs),
        .rt    (inRt),
        .rd    (inRd),
        .imm   (inImm),
        .jaddr (inJAddr),
        .word  (enc_word),
        .ok    (enc_ok)
    );

    assign count   = cnt;
    assign full    = (cnt == DEPTH_W);
    assign inReady = (state == LOAD) && !full;
    assign accept  = inValid && inReady;
    assign write   = accept && enc_ok;
    // Filling the last slot wins over a coincident finish: the FULL state
    // still needs its own finish to reach DONE.
    assign last    = write && (cnt + 11'd1 == DEPTH_W);

    always_comb begin
        state_nx   = state;
        done_entry = 1'b0;
        case (state)
            LOAD: begin
                if (last)
                    state_nx = FULL;
                else if (finish)
                    state_nx = DONE;
            end
            FULL: begin
                if (finish)
                    state_nx = DONE;
            end
            DONE:    state_nx = DONE;
            default: state_nx = LOAD;
        endcase
        done_entry = (state != DONE) && (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            cnt      <= 11'd0;
            err      <= 1'b0;
            imWe     <= 1'b0;
            loadDone <= 1'b0;
            imWData  <= 32'h0;
            imAddr   <= BASE_ADDR;
        end else begin
            state    <= state_nx;
            loadDone <= done_entry;
            imWe     <= write;
            if (write) begin
                imWData <= enc_word;
                imAddr  <= BASE_ADDR + {19'h0, cnt, 2'b00};
                cnt     <= cnt + 11'd1;
            end
            if (accept && !enc_ok)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: table of all mnemonics streamed back-to-back, then
// hand-written sequences for invalid opcodes, reset, finish and full.

module tb_instr_encoder_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: default depth, base 0
    logic        a_valid, a_ready, a_fin, a_we, a_full, a_done, a_err;
    logic [3:0]  a_mnem;
    logic [4:0]  a_rs, a_rt, a_rd;
    logic [15:0] a_imm;
    logic [25:0] a_jaddr;
    logic [31:0] a_addr, a_data;
    logic [10:0] a_cnt;

    // DUT B: depth 4, base 0x100
    logic        b_valid, b_ready, b_fin, b_we, b_full, b_done, b_err;
    logic [3:0]  b_mnem;
    logic [25:0] b_jaddr;
    logic [31:0] b_addr, b_data;
    logic [10:0] b_cnt;

    instr_encoder_loader dut (
        .clk(clk), .reset(rst), .inValid(a_valid), .inReady(a_ready),
        .inMnem(a_mnem), .inRs(a_rs), .inRt(a_rt), .inRd(a_rd),
        .inImm(a_imm), .inJAddr(a_jaddr), .finish(a_fin),
        .imWe(a_we), .imAddr(a_addr), .imWData(a_data), .count(a_cnt),
        .full(a_full), .loadDone(a_done), .err(a_err)
    );

    instr_encoder_loader #(.DEPTH(4), .BASE_ADDR(32'h100)) dut4 (
        .clk(clk), .reset(rst), .inValid(b_valid), .inReady(b_ready),
        .inMnem(b_mnem), .inRs(5'd0), .inRt(5'd0), .inRd(5'd0),
        .inImm(16'h0), .inJAddr(b_jaddr), .finish(b_fin),
        .imWe(b_we), .imAddr(b_addr), .imWData(b_data), .count(b_cnt),
        .full(b_full), .loadDone(b_done), .err(b_err)
    );

    typedef struct {
        logic [3:0]  mnem;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] jaddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input logic v, input logic [3:0] m, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [15:0] imm, input logic [25:0] ja, input logic fin);
        a_valid = v; a_mnem = m; a_rs = rs; a_rt = rt; a_rd = rd;
        a_imm = imm; a_jaddr = ja; a_fin = fin;
    endtask

    initial begin
        // unused fields carry junk to show they are ignored
        vecs[0]  = '{4'd7,  5'd0,  5'd1,  5'd17, 16'h0005, 26'h2AAAAAA, 32'h20010005};
        vecs[1]  = '{4'd0,  5'd1,  5'd2,  5'd9,  16'h0004, 26'h1555555, 32'h8C220004};
        vecs[2]  = '{4'd3,  5'd7,  5'd7,  5'd7,  16'hBEEF, 26'h0000100, 32'h0C000100};
        vecs[3]  = '{4'd11, 5'd31, 5'd5,  5'd7,  16'hBEEF, 26'h2AAAAAA, 32'h03E00008};
        vecs[4]  = '{4'd1,  5'd3,  5'd4,  5'd1,  16'hFFFF, 26'h2AAAAAA, 32'hAC64FFFF};
        vecs[5]  = '{4'd2,  5'd1,  5'd1,  5'd1,  16'hBEEF, 26'h3FFFFFF, 32'h0BFFFFFF};
        vecs[6]  = '{4'd4,  5'd5,  5'd6,  5'd0,  16'h8000, 26'h2AAAAAA, 32'h10A68000};
        vecs[7]  = '{4'd5,  5'd7,  5'd8,  5'd0,  16'h0010, 26'h2AAAAAA, 32'h14E80010};
        vecs[8]  = '{4'd6,  5'd9,  5'd10, 5'd0,  16'h00FF, 26'h2AAAAAA, 32'h392A00FF};
        vecs[9]  = '{4'd8,  5'd1,  5'd2,  5'd3,  16'hBEEF, 26'h2AAAAAA, 32'h00221820};
        vecs[10] = '{4'd9,  5'd1,  5'd2,  5'd3,  16'hBEEF, 26'h2AAAAAA, 32'h00221822};
        vecs[11] = '{4'd10, 5'd31, 5'd30, 5'd29, 16'hBEEF, 26'h2AAAAAA, 32'h03FEE82A};

        rst = 1'b1;
        req_a(1'b1, 4'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1); // reset dominates
        b_valid = 1'b1; b_mnem = 4'd2; b_jaddr = 26'h0; b_fin = 1'b1;
        tick(); tick();

        chk("rst_count", 32'(a_cnt), 32'd0);
        chk("rst_we", 32'(a_we), 32'd0);
        chk("rst_full", 32'(a_full), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_data", a_data, 32'h0);
        chk("rst_addr", a_addr, 32'h0);
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_b_addr", b_addr, 32'h100);

        rst = 1'b0;
        b_valid = 1'b0; b_fin = 1'b0;
        req_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        tick();

        // back-to-back stream, one word per cycle
        for (int i = 0; i < 12; i++) begin
            req_a(1'b1, vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                  vecs[i].imm, vecs[i].jaddr, 1'b0);
            tick();
            chk($sformatf("vec%0d_we", i), 32'(a_we), 32'd1);
            chk($sformatf("vec%0d_data", i), a_data, vecs[i].exp);
            chk($sformatf("vec%0d_addr", i), a_addr, 32'(i * 4));
            chk($sformatf("vec%0d_count", i), 32'(a_cnt), 32'(i + 1));
        end
        req_a(1'b0, 4'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        tick();
        chk("idle_we", 32'(a_we), 32'd0);
        chk("idle_count", 32'(a_cnt), 32'd12);

        // invalid mnemonic after a reset, then SUB
        rst = 1'b1; tick(); rst = 1'b0;
        req_a(1'b1, 4'd13, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        tick();
        chk("inv_we", 32'(a_we), 32'd0);
        chk("inv_count", 32'(a_cnt), 32'd0);
        chk("inv_err", 32'(a_err), 32'd1);
        req_a(1'b1, 4'd9, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        tick();
        chk("sub_we", 32'(a_we), 32'd1);
        chk("sub_data", a_data, 32'h00221822);
        chk("sub_addr", a_addr, 32'h0);
        chk("sub_err_sticky", 32'(a_err), 32'd1);
        req_a(1'b1, 4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        tick();
        req_a(1'b1, 4'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        tick(); tick();
        chk("three_count", 32'(a_cnt), 32'd3);
        chk("three_addr", a_addr, 32'h8);

        // reset mid-load with err set
        req_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_count", 32'(a_cnt), 32'd0);
        chk("rst2_err", 32'(a_err), 32'd0);
        chk("rst2_ready", 32'(a_ready), 32'd1);

        // finish together with an accepted ADDI
        req_a(1'b1, 4'd7, 5'd0, 5'd1, 5'd0, 16'h0005, 26'h0, 1'b1);
        tick();
        chk("fin_we", 32'(a_we), 32'd1);
        chk("fin_data", a_data, 32'h20010005);
        chk("fin_addr", a_addr, 32'h0);
        chk("fin_done", 32'(a_done), 32'd1);
        chk("fin_ready", 32'(a_ready), 32'd0);
        req_a(1'b1, 4'd8, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        tick();
        chk("done_pulse_end", 32'(a_done), 32'd0);
        chk("done_we", 32'(a_we), 32'd0);
        chk("done_count", 32'(a_cnt), 32'd1);
        chk("done_ready", 32'(a_ready), 32'd0);
        req_a(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);

        // depth-4 instance fills up
        for (int i = 0; i < 4; i++) begin
            b_valid = 1'b1; b_mnem = 4'd2; b_jaddr = 26'(i + 1);
            tick();
            chk($sformatf("d4_%0d_we", i), 32'(b_we), 32'd1);
            chk($sformatf("d4_%0d_data", i), b_data, 32'h08000001 + 32'(i));
            chk($sformatf("d4_%0d_addr", i), b_addr, 32'h100 + 32'(i * 4));
        end
        chk("d4_full", 32'(b_full), 32'd1);
        chk("d4_ready", 32'(b_ready), 32'd0);
        chk("d4_count", 32'(b_cnt), 32'd4);
        b_jaddr = 26'h3F; tick();
        chk("d4_held_we", 32'(b_we), 32'd0);
        chk("d4_held_count", 32'(b_cnt), 32'd4);
        chk("d4_no_done", 32'(b_done), 32'd0);
        b_fin = 1'b1; tick();
        chk("d4_done", 32'(b_done), 32'd1);
        chk("d4_done_we", 32'(b_we), 32'd0);
        tick();
        chk("d4_done_once", 32'(b_done), 32'd0);
        chk("d4_err", 32'(b_err), 32'd0);
        b_valid = 1'b0; b_fin = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
